// File: rtl/rvfi_compare_pkg.sv
// Shared types for the RVFI retirement comparator.
// Entry fields are sized for the widest supported XLEN (64).
package rvfi_compare_pkg;

  localparam int XLEN_MAX = 64;

  localparam int F_PC       = 0;
  localparam int F_INSN     = 1;
  localparam int F_RD_ADDR  = 2;
  localparam int F_RD_WDATA = 3;
  localparam int F_TRAP     = 4;
  localparam int NFIELDS    = 5;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         insn;
    logic [4:0]          rd_addr;
    logic [XLEN_MAX-1:0] rd_wdata;
    logic                trap;
  } rvfi_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ERROR = 1'b1
  } state_t;

endpackage

// File: rtl/rvfi_compare_fifo.sv
// Retirement FIFO; a push on a full FIFO succeeds only
// when a pop frees a slot in the same cycle.
module rvfi_compare_fifo
  import rvfi_compare_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = rvfi_entry_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     data_i,
  output T     data_o,
  output logic empty_o,
  output logic full_o,
  output logic drop_o
);

  localparam int AW = $clog2(DEPTH);

  T             r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_wr;
  logic         w_rd;

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_rd   = pop_i && !empty_o;
  assign w_wr   = push_i && (!full_o || w_rd);
  assign drop_o = push_i && !w_wr;
  assign data_o = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rvfi_compare.sv
// Lock-step RVFI retirement comparator (DUT vs reference).
// Optional: RVFI_COMPARE_TRAP_CHECK_EN enables trap comparison.
module rvfi_compare
  import rvfi_compare_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dut_valid_i,
  input  logic [XLEN-1:0] dut_pc_i,
  input  logic [31:0]     dut_insn_i,
  input  logic [4:0]      dut_rd_addr_i,
  input  logic [XLEN-1:0] dut_rd_wdata_i,
  input  logic            dut_trap_i,
  input  logic            ref_valid_i,
  input  logic [XLEN-1:0] ref_pc_i,
  input  logic [31:0]     ref_insn_i,
  input  logic [4:0]      ref_rd_addr_i,
  input  logic [XLEN-1:0] ref_rd_wdata_i,
  input  logic            ref_trap_i,
  output logic            mismatch_o,
  output logic [4:0]      mismatch_field_o,
  output logic [31:0]     match_count_o,
  output logic            overflow_o,
  output logic            timeout_o,
  output logic            error_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  rvfi_entry_t     w_dut_in;
  rvfi_entry_t     w_ref_in;
  rvfi_entry_t     w_dut_hd;
  rvfi_entry_t     w_ref_hd;
  logic            w_dut_empty;
  logic            w_ref_empty;
  logic            w_dut_full;
  logic            w_ref_full;
  logic            w_dut_drop;
  logic            w_ref_drop;
  logic            w_pop;
  logic            w_both_trap;
  logic [4:0]      w_diff;
  logic            w_mis;
  logic            w_ovf;
  logic            w_tmo;
  logic            w_one_side;
  logic [TW-1:0]   w_tcnt_nxt;
  logic            r_mismatch;
  logic [4:0]      r_field;
  logic [31:0]     r_match_cnt;
  logic            r_overflow;
  logic            r_timeout;
  logic [TW-1:0]   r_tcnt;

  always_comb begin
    w_dut_in          = '0;
    w_dut_in.pc       = XLEN_MAX'(dut_pc_i);
    w_dut_in.insn     = dut_insn_i;
    w_dut_in.rd_addr  = dut_rd_addr_i;
    w_dut_in.rd_wdata = XLEN_MAX'(dut_rd_wdata_i);
    w_dut_in.trap     = dut_trap_i;
    w_ref_in          = '0;
    w_ref_in.pc       = XLEN_MAX'(ref_pc_i);
    w_ref_in.insn     = ref_insn_i;
    w_ref_in.rd_addr  = ref_rd_addr_i;
    w_ref_in.rd_wdata = XLEN_MAX'(ref_rd_wdata_i);
    w_ref_in.trap     = ref_trap_i;
  end

  assign w_pop = (r_state == ST_RUN) &&
                 !w_dut_empty && !w_ref_empty;

  rvfi_compare_fifo #(
    .DEPTH (DEPTH),
    .T     (rvfi_entry_t)
  ) u_dut_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (dut_valid_i),
    .pop_i   (w_pop),
    .data_i  (w_dut_in),
    .data_o  (w_dut_hd),
    .empty_o (w_dut_empty),
    .full_o  (w_dut_full),
    .drop_o  (w_dut_drop)
  );

  rvfi_compare_fifo #(
    .DEPTH (DEPTH),
    .T     (rvfi_entry_t)
  ) u_ref_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ref_valid_i),
    .pop_i   (w_pop),
    .data_i  (w_ref_in),
    .data_o  (w_ref_hd),
    .empty_o (w_ref_empty),
    .full_o  (w_ref_full),
    .drop_o  (w_ref_drop)
  );

  // Both-trapped retirements carry no meaningful rd write.
  always_comb begin
    w_both_trap        = 1'b0;
    w_diff             = '0;
    w_diff[F_PC]       = w_dut_hd.pc != w_ref_hd.pc;
    w_diff[F_INSN]     = w_dut_hd.insn != w_ref_hd.insn;
`ifdef RVFI_COMPARE_TRAP_CHECK_EN
    w_both_trap        = w_dut_hd.trap && w_ref_hd.trap;
    w_diff[F_TRAP]     = w_dut_hd.trap != w_ref_hd.trap;
`endif
    w_diff[F_RD_ADDR]  = !w_both_trap &&
      (w_dut_hd.rd_addr != w_ref_hd.rd_addr);
    w_diff[F_RD_WDATA] = !w_both_trap &&
      !((w_dut_hd.rd_addr == 5'd0) &&
        (w_ref_hd.rd_addr == 5'd0)) &&
      (w_dut_hd.rd_wdata != w_ref_hd.rd_wdata);
  end

`ifndef RVFI_COMPARE_TRAP_CHECK_EN
  logic w_unused_trap;
  assign w_unused_trap = w_dut_hd.trap ^ w_ref_hd.trap;
`endif

  logic w_unused_full;
  assign w_unused_full = w_dut_full ^ w_ref_full;

  assign w_mis      = w_pop && (w_diff != '0);
  assign w_ovf      = w_dut_drop || w_ref_drop;
  assign w_one_side = w_dut_empty ^ w_ref_empty;

  always_comb begin
    w_tcnt_nxt = r_tcnt;
    if (r_state == ST_RUN) begin
      if (!w_one_side)
        w_tcnt_nxt = '0;
      else if (r_tcnt != TW'(TIMEOUT))
        w_tcnt_nxt = r_tcnt + TW'(1);
    end
  end

  assign w_tmo = (r_state == ST_RUN) &&
                 (w_tcnt_nxt == TW'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:   if (w_mis || w_ovf || w_tmo)
                  w_state_nxt = ST_ERROR;
      ST_ERROR: w_state_nxt = ST_ERROR;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mismatch  <= 1'b0;
      r_field     <= '0;
      r_match_cnt <= '0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      r_mismatch <= w_mis;
      r_tcnt     <= w_tcnt_nxt;
      if (w_pop) r_field <= w_diff;
      if (w_pop && (w_diff == '0) &&
          (r_match_cnt != 32'hFFFF_FFFF))
        r_match_cnt <= r_match_cnt + 32'd1;
      if (w_ovf) r_overflow <= 1'b1;
      if (w_tmo) r_timeout  <= 1'b1;
    end
  end

  assign mismatch_o       = r_mismatch;
  assign mismatch_field_o = r_field;
  assign match_count_o    = r_match_cnt;
  assign overflow_o       = r_overflow;
  assign timeout_o        = r_timeout;
  assign error_o          = (r_state == ST_ERROR);

endmodule
